// File: rtl/vec_elem_sequencer.sv
// vec_elem_sequencer
//   Memory-to-memory vector control stage feeding a 16-bit combinational ALU.
//   On Start it walks Length elements: reads A[i] and B[i] through the single
//   shared memory port, registers them as ALU operands, and writes the ALU
//   result back to D[i]. Elements are processed strictly one at a time.
//
// Ports
//   CLK, Reset        clock (rising edge), synchronous active-high reset
//   Start             begin operation (accepted only in IDLE)
//   OpIn              ALU opcode, latched at Start
//   BaseA/BaseB/BaseD source/destination base addresses, latched at Start
//   Length            element count, latched at Start
//   MemAddr/MemRead   read port; data returns on MemRData one cycle later
//   MemWrite/MemWData write port; memory captures at the clock edge
//   ALUA/ALUB/ALUOp   registered operands and latched opcode to the ALU
//   ALUResult         combinational ALU output
//   Busy              high whenever not IDLE
//   Done              one-cycle completion pulse
//
// Build option
//   VEC_SCALAR_EN     adds ScalarMode/ScalarB; in scalar mode operand B is a
//                     constant captured at Start and the B read is skipped.

module vec_elem_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [4:0]        OpIn,
  input  logic [ADDR_W-1:0] BaseA,
  input  logic [ADDR_W-1:0] BaseB,
  input  logic [ADDR_W-1:0] BaseD,
  input  logic [LEN_W-1:0]  Length,
`ifdef VEC_SCALAR_EN
  input  logic              ScalarMode,
  input  logic [DATA_W-1:0] ScalarB,
`endif
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic [DATA_W-1:0] ALUA,
  output logic [DATA_W-1:0] ALUB,
  output logic [4:0]        ALUOp,
  input  logic [DATA_W-1:0] ALUResult,
  output logic              Busy,
  output logic              Done
);

  // state | meaning
  // IDLE  | waiting for Start; parameters latched on Start
  // RD_A  | read strobe at BaseA+idx
  // RD_B  | read strobe at BaseB+idx; A data arrives and is captured
  // EXE   | no strobe; last read data arrives and is captured
  // WR    | write ALU result to BaseD+idx; advance or finish
  // FIN   | Done pulse, back to IDLE
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXE  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W-1:0] base_d_q, base_d_d;
  logic [4:0]        op_q, op_d;
  logic [DATA_W-1:0] alua_q, alua_d;
  logic [DATA_W-1:0] alub_q, alub_d;
  logic              scalar_q, scalar_d;

  logic              scalar_start;
  logic [DATA_W-1:0] scalar_val;
  logic [ADDR_W-1:0] idx_addr;
  logic              last_elem;

`ifdef VEC_SCALAR_EN
  assign scalar_start = ScalarMode;
  assign scalar_val   = ScalarB;
`else
  assign scalar_start = 1'b0;
  assign scalar_val   = '0;
`endif

  // Address offsets wrap modulo 2^ADDR_W with the base addition.
  assign idx_addr  = ADDR_W'(idx_q);
  // Only evaluated in WR, where len_q is known to be non-zero.
  assign last_elem = (idx_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_d_d = base_d_q;
    op_d     = op_q;
    alua_d   = alua_q;
    alub_d   = alub_q;
    scalar_d = scalar_q;
    MemAddr  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemWData = '0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d     = OpIn;
          base_a_d = BaseA;
          base_b_d = BaseB;
          base_d_d = BaseD;
          len_d    = Length;
          idx_d    = '0;
          scalar_d = scalar_start;
          if (scalar_start) begin
            alub_d = scalar_val;
          end
          state_d  = (Length == '0) ? S_FIN : S_RD_A;
        end
      end
      S_RD_A: begin
        MemAddr = base_a_q + idx_addr;
        MemRead = 1'b1;
        state_d = scalar_q ? S_EXE : S_RD_B;
      end
      S_RD_B: begin
        MemAddr = base_b_q + idx_addr;
        MemRead = 1'b1;
        alua_d  = MemRData;
        state_d = S_EXE;
      end
      S_EXE: begin
        // In scalar mode the only read was A, so it lands here instead.
        if (scalar_q) begin
          alua_d = MemRData;
        end else begin
          alub_d = MemRData;
        end
        state_d = S_WR;
      end
      S_WR: begin
        MemAddr  = base_d_q + idx_addr;
        MemWrite = 1'b1;
        MemWData = ALUResult;
        if (last_elem) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_RD_A;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_d_q <= '0;
      op_q     <= '0;
      alua_q   <= '0;
      alub_q   <= '0;
      scalar_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_d_q <= base_d_d;
      op_q     <= op_d;
      alua_q   <= alua_d;
      alub_q   <= alub_d;
      scalar_q <= scalar_d;
    end
  end

  assign ALUA  = alua_q;
  assign ALUB  = alub_q;
  assign ALUOp = op_q;
  assign Busy  = (state_q != S_IDLE);
  assign Done  = (state_q == S_FIN);

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Self-checking bench for vec_elem_sequencer: behavioural memory and ALU,
// sequential reference model of D[i] = op(A[i], B[i]).
module tb_vec_elem_sequencer;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic [4:0]  OpIn;
  logic [15:0] BaseA, BaseB, BaseD, Length;
  logic        ScalarMode;
  logic [15:0] ScalarB;
  logic [15:0] MemAddr;
  logic        MemRead, MemWrite;
  logic [15:0] MemWData;
  logic [15:0] MemRData;
  logic [15:0] ALUA, ALUB;
  logic [4:0]  ALUOp;
  logic [15:0] ALUResult;
  logic        Busy, Done;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int errors = 0;
  int checks = 0;

  int          obs_done_k, done_cnt, reads, writes, busy_cnt, excl_bad, zero_bad;
  logic [15:0] rd_addrs[$];
  logic [72:0] rst_snap;

  vec_elem_sequencer dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .OpIn      (OpIn),
    .BaseA     (BaseA),
    .BaseB     (BaseB),
    .BaseD     (BaseD),
    .Length    (Length),
`ifdef VEC_SCALAR_EN
    .ScalarMode(ScalarMode),
    .ScalarB   (ScalarB),
`endif
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .ALUA      (ALUA),
    .ALUB      (ALUB),
    .ALUOp     (ALUOp),
    .ALUResult (ALUResult),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op[2:0])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return b;
      default: return ~(a & b);
    endcase
  endfunction

  assign ALUResult = alu_f(ALUOp, ALUA, ALUB);

  always @(posedge CLK) begin
    if (MemRead) MemRData <= mem[MemAddr];
    if (MemWrite) mem[MemAddr] = MemWData;
  end

  // Reference: elements processed in order, each read before its write.
  task automatic model(input logic [4:0] op, input logic [15:0] ba, input logic [15:0] bb,
                       input logic [15:0] bd, input int n, input logic sc, input logic [15:0] sb);
    logic [15:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = ref_mem[ba + 16'(i)];
      b = sc ? sb : ref_mem[bb + 16'(i)];
      ref_mem[bd + 16'(i)] = alu_f(op, a, b);
    end
  endtask

  // Drives one operation and records observations; k counts cycles after the
  // Start edge (k=1 is the first cycle after it).
  task automatic run_vec(input logic [4:0] op, input logic [15:0] ba, input logic [15:0] bb,
                         input logic [15:0] bd, input logic [15:0] len, input logic sc,
                         input logic [15:0] sb, input int inj_k, input int rst_k);
    int budget;
    obs_done_k = -1; done_cnt = 0; reads = 0; writes = 0; busy_cnt = 0;
    excl_bad = 0; zero_bad = 0; rd_addrs.delete();
    budget = 4 * int'(len) + 12;
    @(negedge CLK);
    Start = 1'b1; OpIn = op; BaseA = ba; BaseB = bb; BaseD = bd; Length = len;
    ScalarMode = sc; ScalarB = sb;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    OpIn = 5'($urandom); BaseA = 16'($urandom); BaseB = 16'($urandom);
    BaseD = 16'($urandom); Length = 16'($urandom); ScalarMode = 1'($urandom);
    ScalarB = 16'($urandom);
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (rst_k > 0 && k == rst_k + 1) begin
        rst_snap = {Busy, Done, MemRead, MemWrite, MemAddr, MemWData, ALUA, ALUB, ALUOp};
        Reset = 1'b0;
        break;
      end
      if (Done) begin
        done_cnt++;
        if (obs_done_k < 0) obs_done_k = k;
      end
      if (Busy) busy_cnt++;
      if (MemRead) begin reads++; rd_addrs.push_back(MemAddr); end
      if (MemWrite) writes++;
      if (MemRead && MemWrite) excl_bad++;
      if (!MemRead && !MemWrite && (MemAddr != 16'd0 || MemWData != 16'd0)) zero_bad++;
      if (k == inj_k) begin Start = 1'b1; Length = 16'd9; end
      else if (k == inj_k + 1) Start = 1'b0;
      if (rst_k > 0 && k == rst_k) Reset = 1'b1;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Length = 16'd3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({Busy, Done, MemRead, MemWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {Busy, Done, MemRead, MemWrite});
    end
    checks++;
    if ({MemAddr, MemWData} !== 32'd0) begin
      errors++; $display("FAIL reset_mem got addr=%h wdata=%h exp 0", MemAddr, MemWData);
    end
    checks++;
    if ({ALUA, ALUB, ALUOp} !== 37'd0) begin
      errors++; $display("FAIL reset_alu got A=%h B=%h op=%h exp 0", ALUA, ALUB, ALUOp);
    end
    Start = 1'b0; Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b exp=0", Busy); end
  endtask

  task automatic test_vec_add();
    logic [15:0] ea [4] = '{16'd11, 16'd22, 16'd33, 16'h0001};
    mem[16'h10] = 16'd1;  mem[16'h11] = 16'd2;  mem[16'h12] = 16'd3;  mem[16'h13] = 16'hFFFF;
    mem[16'h20] = 16'd10; mem[16'h21] = 16'd20; mem[16'h22] = 16'd30; mem[16'h23] = 16'd2;
    run_vec(5'd0, 16'h10, 16'h20, 16'h30, 16'd4, 1'b0, 16'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h30 + 16'(i)] !== ea[i]) begin
        errors++; $display("FAIL add_d%0d got=%h exp=%h", i, mem[16'h30 + 16'(i)], ea[i]);
      end
    end
    checks++;
    if (obs_done_k != 17) begin errors++; $display("FAIL add_done_cycle got=%0d exp=17", obs_done_k); end
    checks++;
    if (writes != 4 || reads != 8) begin
      errors++; $display("FAIL add_strobes got wr=%0d rd=%0d exp wr=4 rd=8", writes, reads);
    end
    checks++;
    if (busy_cnt != 17 || done_cnt != 1) begin
      errors++; $display("FAIL add_busy got busy=%0d done=%0d exp 17/1", busy_cnt, done_cnt);
    end
    checks++;
    if (excl_bad != 0 || zero_bad != 0) begin
      errors++; $display("FAIL add_idle_outputs got excl=%0d nonzero=%0d exp 0/0", excl_bad, zero_bad);
    end
  endtask

  task automatic test_zero_len();
    run_vec(5'd0, 16'h40, 16'h50, 16'h60, 16'd0, 1'b0, 16'd0, 0, 0);
    checks++;
    if (obs_done_k != 1 || done_cnt != 1) begin
      errors++; $display("FAIL zero_done got cycle=%0d count=%0d exp 1/1", obs_done_k, done_cnt);
    end
    checks++;
    if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy got=%0d exp=1", busy_cnt); end
    checks++;
    if (reads != 0 || writes != 0) begin
      errors++; $display("FAIL zero_strobes got rd=%0d wr=%0d exp 0/0", reads, writes);
    end
  endtask

  task automatic test_start_busy();
    logic [15:0] bd = 16'h0130;
    for (int i = 0; i < 12; i++) begin
      mem[16'h0110 + 16'(i)] = 16'($urandom);
      mem[16'h0120 + 16'(i)] = 16'($urandom);
    end
    ref_mem = mem;
    model(5'd1, 16'h0110, 16'h0120, bd, 3, 1'b0, 16'd0);
    run_vec(5'd1, 16'h0110, 16'h0120, bd, 16'd3, 1'b0, 16'd0, 5, 0);
    checks++;
    if (writes != 3) begin errors++; $display("FAIL busy_writes got=%0d exp=3", writes); end
    checks++;
    if (obs_done_k != 13 || done_cnt != 1) begin
      errors++; $display("FAIL busy_done got cycle=%0d count=%0d exp 13/1", obs_done_k, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[bd + 16'(i)] !== ref_mem[bd + 16'(i)]) begin
        errors++; $display("FAIL busy_d%0d got=%h exp=%h", i, mem[bd + 16'(i)], ref_mem[bd + 16'(i)]);
      end
    end
  endtask

  task automatic test_start_in_fin();
    run_vec(5'd4, 16'h0200, 16'h0210, 16'h0220, 16'd2, 1'b0, 16'd0, 9, 0);
    checks++;
    if (busy_cnt != 9 || done_cnt != 1) begin
      errors++; $display("FAIL fin_start got busy=%0d done=%0d exp 9/1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bd = 16'h0330;
    ref_mem = mem;
    model(5'd3, 16'h0310, 16'h0320, bd, 2, 1'b0, 16'd0);
    run_vec(5'd3, 16'h0310, 16'h0320, bd, 16'd4, 1'b0, 16'd0, 0, 10);
    checks++;
    if (rst_snap !== 73'd0) begin errors++; $display("FAIL midrst_outputs got=%h exp=0", rst_snap); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[bd + 16'(i)] !== ref_mem[bd + 16'(i)]) begin
        errors++; $display("FAIL midrst_d%0d got=%h exp=%h", i, mem[bd + 16'(i)], ref_mem[bd + 16'(i)]);
      end
    end
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || writes != 2) begin
      errors++; $display("FAIL midrst_idle got busy=%b wr=%0d exp 0/2", Busy, writes);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    ref_mem = mem;
    model(5'd0, 16'hFFFE, 16'h0400, 16'h0410, 3, 1'b0, 16'd0);
    run_vec(5'd0, 16'hFFFE, 16'h0400, 16'h0410, 16'd3, 1'b0, 16'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_addrs.size() != 6 || rd_addrs[2*i] !== ea[i]) begin
        errors++; $display("FAIL wrap_addr%0d got=%h exp=%h (reads=%0d)", i,
                           (rd_addrs.size() > 2*i) ? rd_addrs[2*i] : 16'hxxxx, ea[i], rd_addrs.size());
      end
      checks++;
      if (mem[16'h0410 + 16'(i)] !== ref_mem[16'h0410 + 16'(i)]) begin
        errors++; $display("FAIL wrap_d%0d got=%h exp=%h", i, mem[16'h0410 + 16'(i)], ref_mem[16'h0410 + 16'(i)]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [15:0] ba, bb, bd;
    logic        sc;
    int          n, exp_k, exp_rd, bad;
    for (int it = 0; it < 8; it++) begin
      op = 5'($urandom_range(0, 7));
      n  = $urandom_range(1, 5);
      ba = 16'($urandom); bb = 16'($urandom);
      bd = (it == 0) ? ba : 16'($urandom);
      sc = 1'b0;
`ifdef VEC_SCALAR_EN
      sc = 1'($urandom);
`endif
      ref_mem = mem;
      model(op, ba, bb, bd, n, sc, 16'h1234 + 16'(it));
      run_vec(op, ba, bb, bd, 16'(n), sc, 16'h1234 + 16'(it), 0, 0);
      exp_k  = sc ? 3 * n + 1 : 4 * n + 1;
      exp_rd = sc ? n : 2 * n;
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (mem[bd + 16'(i)] !== ref_mem[bd + 16'(i)]) begin
          errors++; $display("FAIL rand%0d_d%0d got=%h exp=%h", it, i, mem[bd + 16'(i)], ref_mem[bd + 16'(i)]);
        end
      end
      checks++;
      if (obs_done_k != exp_k || writes != n || reads != exp_rd) begin
        errors++; $display("FAIL rand%0d_timing got done=%0d wr=%0d rd=%0d exp %0d/%0d/%0d",
                           it, obs_done_k, writes, reads, exp_k, n, exp_rd);
      end
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (sc) begin
          if (rd_addrs.size() != n || rd_addrs[i] !== ba + 16'(i)) bad++;
        end else begin
          if (rd_addrs.size() != 2 * n || rd_addrs[2*i] !== ba + 16'(i) ||
              rd_addrs[2*i+1] !== bb + 16'(i)) bad++;
        end
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_rd_addrs got bad=%0d exp=0", it, bad); end
    end
  endtask

`ifdef VEC_SCALAR_EN
  task automatic test_scalar();
    int hits_b = 0;
    mem[16'h0500] = 16'd7; mem[16'h0501] = 16'd8;
    run_vec(5'd0, 16'h0500, 16'h0510, 16'h0520, 16'd2, 1'b1, 16'd5, 0, 0);
    foreach (rd_addrs[i]) if (rd_addrs[i] == 16'h0510 || rd_addrs[i] == 16'h0511) hits_b++;
    checks++;
    if (mem[16'h0520] !== 16'd12 || mem[16'h0521] !== 16'd13) begin
      errors++; $display("FAIL scalar_d got=%0d,%0d exp=12,13", mem[16'h0520], mem[16'h0521]);
    end
    checks++;
    if (obs_done_k != 7 || hits_b != 0 || reads != 2) begin
      errors++; $display("FAIL scalar_seq got done=%0d bhits=%0d rd=%0d exp 7/0/2", obs_done_k, hits_b, reads);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    Reset = 1'b1; Start = 1'b0; OpIn = '0; BaseA = '0; BaseB = '0; BaseD = '0;
    Length = '0; ScalarMode = 1'b0; ScalarB = '0; MemRData = '0;
    test_reset();
    test_vec_add();
    test_zero_len();
    test_start_busy();
    test_start_in_fin();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef VEC_SCALAR_EN
    test_scalar();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_elem_sequencer.md
Name: vec_elem_sequencer

Overview:
- Memory-to-memory vector control stage that sits directly upstream of the 16-bit combinational ALU and consumes its result.
- On Start, walks N elements: reads A[i] and B[i] from data memory, presents them with the opcode to the ALU, and writes the ALU result to D[i].
- One element at a time, no overlap; single shared memory port.

Parameters:
- DATA_W, 16, operand/result width; matches ALU A/B/ALUOut.
- ADDR_W, 16, memory address width.
- LEN_W, 16, vector length counter width.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin operation; sampled only in IDLE.
- OpIn  input  5  ALU opcode, latched at Start.
- BaseA  input  ADDR_W  source A base address, latched at Start.
- BaseB  input  ADDR_W  source B base address, latched at Start.
- BaseD  input  ADDR_W  destination base address, latched at Start.
- Length  input  LEN_W  element count N, latched at Start.
- MemAddr  output  ADDR_W  memory address.
- MemRead  output  1  read strobe; data is valid on MemRData the following cycle.
- MemWrite  output  1  write strobe; memory writes MemWData to MemAddr at the edge.
- MemWData  output  DATA_W  write data.
- MemRData  input  DATA_W  read data, 1-cycle latency.
- ALUA  output  DATA_W  ALU operand A (register).
- ALUB  output  DATA_W  ALU operand B (register).
- ALUOp  output  5  latched opcode to the ALU.
- ALUResult  input  DATA_W  combinational ALU output.
- Busy  output  1  high when state is not IDLE.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - State goes to IDLE; element index = 0.
  - All outputs 0, including ALUA, ALUB, ALUOp and MemAddr.
  - Reset takes priority over every other condition.
- States: IDLE, RD_A, RD_B, EXE, WR, FIN.
- IDLE:
  - On Start=1, latch OpIn, bases and Length, and set idx=0.
  - If Length==0, go to FIN; otherwise go to RD_A.
- RD_A: MemAddr=BaseA+idx, MemRead=1; go to RD_B.
- RD_B: MemAddr=BaseB+idx, MemRead=1; ALUA<=MemRData; go to EXE.
- EXE: ALUB<=MemRData; no memory strobe; go to WR.
- WR:
  - MemAddr=BaseD+idx, MemWrite=1, MemWData=ALUResult.
  - If idx==N-1, go to FIN; otherwise idx<=idx+1 and go to RD_A.
- FIN: Done=1 for exactly one cycle; go to IDLE.
- Strobe exclusivity: MemRead and MemWrite are never high together. Both are 0 in IDLE, EXE and FIN.
- Outputs in non-access states:
  - MemAddr, MemWData = 0 whenever no strobe is asserted.
  - ALUA, ALUB, ALUOp hold their last values.
- Throughput: 4 cycles per element.
- Latency: Start sampled at edge t → Done high in cycle t+4N+1. For N=0, Done is high in cycle t+1.
- Address arithmetic: base+idx is computed modulo 2^ADDR_W; it wraps silently with no error flag.
- Start while Busy=1 is ignored; latched parameters are unaffected.
- Start asserted in the FIN cycle is ignored; a new Start is accepted only in IDLE.
- Reset mid-operation: next cycle is IDLE with no strobes; the partially processed element is not written.
- No overlap checking between the D and A/B regions. In-place operation (BaseD==BaseA) is legal because element i is read before it is written.

Optional Feature:
- Macro: VEC_SCALAR_EN.
- Defined:
  - Adds input ports ScalarMode (1) and ScalarB (DATA_W), both latched at Start.
  - When latched ScalarMode=1, ALUB<=ScalarB at Start and RD_B is skipped.
  - RD_A → EXE; EXE captures MemRData into ALUA (not ALUB).
  - Throughput: 3 cycles per element. Done in cycle t+3N+1.
  - When latched ScalarMode=0, behaviour is identical to the non-macro build.
- Undefined: those ports do not exist; behaviour is exactly as described in Behaviour.

Test Plan:
- Vector add, N=4, OpIn=0:
  - Stimulus: A=[1,2,3,0xFFFF] at 0x10, B=[10,20,30,2] at 0x20, BaseD=0x30.
  - Expected: mem[0x30..0x33]=[11,22,33,0x0001]; Done at t+17; exactly 4 writes and 8 reads.
- Zero length, N=0:
  - Expected: Done in cycle t+1, Busy high for 1 cycle, no MemRead or MemWrite.
- Start ignored while busy:
  - Stimulus: N=3 SUB (OpIn=1); pulse Start with Length=9 mid-run.
  - Expected: exactly 3 results written; Done at t+13; a single Done pulse.
- Reset mid-operation:
  - Stimulus: N=4 run; assert Reset during element 2 RD_B.
  - Expected: next cycle Busy=0 and all outputs 0; elements 0–1 written, elements 2–3 untouched.
- Address wrap:
  - Stimulus: BaseA=0xFFFE, N=3.
  - Expected: reads at 0xFFFE, 0xFFFF, 0x0000; results correct.
- Scalar mode (VEC_SCALAR_EN, ScalarMode=1, ScalarB=5, OpIn=0):
  - Stimulus: N=2, A=[7,8].
  - Expected: D=[12,13]; no reads at BaseB; Done at t+7.
